// File: rtl/fifo_drain_ctrl.sv
// Pops a registered-read FIFO and re-times the words into a valid/ready stream framed in bursts.
// Optional: define DRAIN_STATS_EN to enable the saturating WORD_CNT handshake counter.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  DRAIN_EN,
    input  logic                  FIFO_EMPTY,
    input  logic                  FIFO_WR_MON,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    output logic                  FIFO_RD_EN,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    output logic                  BUSY,
    output logic [15:0]           WORD_CNT
);

    localparam int                BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        STOPPING
    } state_t;

    state_t                  state;
    logic [1:0]              count;
    logic [1:0]              head;
    logic [1:0]              tail;
    logic                    pending;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [DATA_WIDTH-1:0]   buf_data [3];
    logic [2:0]              buf_last;

    logic                    pop;
    logic                    capture;
    logic                    drained;
    logic [2:0]              occupancy;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // The in-flight word reserves a slot, so a read is only issued if it is sure to fit.
    assign occupancy  = {1'b0, count} + {2'b00, pending};
    assign drained    = (occupancy == 3'd0);
    assign capture    = pending;
    assign pop        = M_VALID && M_READY;

    assign FIFO_RD_EN = (state == ACTIVE) && !FIFO_EMPTY && (occupancy <= 3'd2);
    assign M_VALID    = (count != 2'd0);
    assign M_DATA     = buf_data[head];
    assign M_LAST     = buf_last[head];
    assign BUSY       = (state != IDLE);

    // NOTE: non-blocking assignments so every register below reacts to pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            count    <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
            pending  <= 1'b0;
            beat_cnt <= '0;
            buf_last <= '0;
            // NOTE: the three entries are flops, not RAM, and are reset so M_DATA reads 0 out of reset.
            for (int i = 0; i < 3; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            pending <= FIFO_RD_EN && !FIFO_EMPTY && !FIFO_WR_MON;

            if (capture) begin
                buf_data[tail] <= FIFO_DOUT;
                buf_last[tail] <= (beat_cnt == BEAT_MAX);
                tail           <= ptr_inc(tail);
                beat_cnt       <= (beat_cnt == BEAT_MAX) ? '0 : beat_cnt + 1'b1;
            end

            if (pop) begin
                head <= ptr_inc(head);
            end

            if (capture && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !capture) begin
                count <= count - 2'd1;
            end

            // DRAIN_EN wins in STOPPING so a re-enable never bounces through IDLE.
            case (state)
                IDLE: begin
                    if (DRAIN_EN) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!DRAIN_EN) state <= drained ? IDLE : STOPPING;
                end
                STOPPING: begin
                    if (DRAIN_EN)     state <= ACTIVE;
                    else if (drained) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DRAIN_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WORD_CNT <= 16'd0;
        end else if (pop && (WORD_CNT != 16'hFFFF)) begin
            WORD_CNT <= WORD_CNT + 16'd1;
        end
    end
`else
    assign WORD_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a queue-based FIFO environment plus a word-level scoreboard
// (words read from the FIFO must reappear in order, framed every BURST_LEN beats).
`timescale 1ns/1ps
module tb_fifo_drain_ctrl;

    localparam int DW = 8;
    localparam int BL = 4;

`ifdef DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          DRAIN_EN;
    logic          FIFO_EMPTY;
    logic          FIFO_WR_MON;
    logic [DW-1:0] FIFO_DOUT;
    logic          FIFO_RD_EN;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic          M_LAST;
    logic          BUSY;
    logic [15:0]   WORD_CNT;

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DRAIN_EN   (DRAIN_EN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_WR_MON(FIFO_WR_MON),
        .FIFO_DOUT  (FIFO_DOUT),
        .FIFO_RD_EN (FIFO_RD_EN),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
        .M_LAST     (M_LAST),
        .BUSY       (BUSY),
        .WORD_CNT   (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q [$];   // FIFO contents
    logic [DW-1:0] exp_q  [$];   // words read from the FIFO and not yet delivered
    logic [DW-1:0] got_q  [$];
    logic          got_last [$];
    int            got_cyc [$];
    int            cyc = 0;
    int            acc_cnt = 0;
    int            delivered = 0;
    int            mstate = 0;   // 0 idle, 1 active, 2 stopping
    bit            pend_m = 1'b0;
    bit            acc_s = 1'b0;
    bit            wr_s = 1'b0;
    logic [DW-1:0] wr_data = '0;
    int            first_rd_cyc = -1;
    int            first_val_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        mstate    = 0;
        pend_m    = 1'b0;
        acc_s     = 1'b0;
        delivered = 0;
    endfunction

    // Runs at the falling edge: compare, then advance the model with the pre-edge values.
    task automatic observe();
        int occ;
        int wexp;
        bit exp_valid;
        bit exp_rd;
        wr_s = FIFO_WR_MON;
        if (!RST_N) begin
            model_reset();
            return;
        end
        occ       = exp_q.size();
        exp_valid = (occ - int'(pend_m)) != 0;
        exp_rd    = (mstate == 1) && !FIFO_EMPTY && (occ <= 2);
        wexp      = STATS ? ((delivered > 65535) ? 65535 : delivered) : 0;
        check("rd_en", FIFO_RD_EN, exp_rd);
        check("rd_while_empty", FIFO_RD_EN && FIFO_EMPTY, 0);
        check("busy", BUSY, mstate != 0);
        check("m_valid", M_VALID, exp_valid);
        check("word_cnt", WORD_CNT, wexp);
        if (exp_valid) begin
            check("m_data", M_DATA, exp_q[0]);
            check("m_last", M_LAST, (delivered % BL) == BL - 1);
        end
        if (FIFO_RD_EN && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (M_VALID && first_val_cyc < 0) first_val_cyc = cyc;
        acc_s = FIFO_RD_EN && !FIFO_EMPTY && !FIFO_WR_MON;
        case (mstate)
            0: if (DRAIN_EN) mstate = 1;
            1: if (!DRAIN_EN) mstate = (occ != 0) ? 2 : 0;
            default: begin
                if (DRAIN_EN)      mstate = 1;
                else if (occ == 0) mstate = 0;
            end
        endcase
        if (exp_valid && M_READY) begin
            got_q.push_back(M_DATA);
            got_last.push_back(M_LAST);
            got_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            delivered++;
        end
    endtask

    // Runs just after the rising edge: the FIFO answers an accepted read with registered DOUT.
    task automatic fifo_update();
        if (acc_s && fifo_q.size() != 0) begin
            FIFO_DOUT = fifo_q.pop_front();
            exp_q.push_back(FIFO_DOUT);
            acc_cnt++;
        end else begin
            FIFO_DOUT = DW'($urandom);
        end
        if (wr_s) fifo_q.push_back(wr_data);
        pend_m     = acc_s;
        FIFO_EMPTY = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic tick();
        @(negedge CLK);
        observe();
        @(posedge CLK);
        #1;
        fifo_update();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        check("rst_rd_en", FIFO_RD_EN, 0);
        check("rst_m_valid", M_VALID, 0);
        check("rst_m_data", M_DATA, 0);
        check("rst_m_last", M_LAST, 0);
        check("rst_busy", BUSY, 0);
        check("rst_word_cnt", WORD_CNT, 0);
        model_reset();
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
        FIFO_EMPTY = (fifo_q.size() == 0);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, got_q.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N       = 1'b1;
        DRAIN_EN    = 1'b0;
        FIFO_EMPTY  = 1'b1;
        FIFO_WR_MON = 1'b0;
        FIFO_DOUT   = '0;
        M_READY     = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // Four words, sink always ready: latency, back-to-back beats, framing.
        clear_log();
        load(8'h11, 1); load(8'h22, 1); load(8'h33, 1); load(8'h44, 1);
        first_rd_cyc  = -1;
        first_val_cyc = -1;
        M_READY  = 1'b1;
        DRAIN_EN = 1'b1;
        run_until(4, 20, "t1_count");
        if (got_q.size() == 4) begin
            check("t1_data0", got_q[0], 8'h11);
            check("t1_data3", got_q[3], 8'h44);
            check("t1_last", {got_last[0], got_last[1], got_last[2], got_last[3]}, 4'b0001);
            check("t1_back_to_back", got_cyc[3] - got_cyc[0], 3);
        end
        check("t1_latency", first_val_cyc - first_rd_cyc, 2);
        tick();
        tick();

        // Six words with a stalled sink: only three reads fit, then full delivery in order.
        clear_log();
        M_READY = 1'b0;
        acc_cnt = 0;
        load(8'hA0, 6);
        repeat (8) tick();
        check("t2_reads_issued", acc_cnt, 3);
        check("t2_valid_full", M_VALID, 1);
        check("t2_rd_blocked", FIFO_RD_EN, 0);
        M_READY = 1'b1;
        run_until(6, 30, "t2_count");
        for (int i = 0; i < got_q.size(); i++) check("t2_order", got_q[i], 8'hA0 + i);

        // FIFO write collides with the second read: dropped, then retried.
        clear_log();
        acc_cnt = 0;
        load(8'hB0, 3);
        tick();
        check("t3_first_read", acc_cnt, 1);
        FIFO_WR_MON = 1'b1;
        wr_data     = 8'hB3;
        tick();
        FIFO_WR_MON = 1'b0;
        check("t3_read_dropped", acc_cnt, 1);
        tick();
        check("t3_read_retried", acc_cnt, 2);
        run_until(4, 20, "t3_count");
        for (int i = 0; i < got_q.size(); i++) check("t3_order", got_q[i], 8'hB0 + i);

        // Drop DRAIN_EN with two buffered words and one in flight.
        clear_log();
        M_READY = 1'b0;
        load(8'hC0, 5);
        for (int k = 0; k < 10 && !(exp_q.size() == 3 && pend_m); k++) tick();
        check("t4_valid_before_stop", M_VALID, 1);
        DRAIN_EN = 1'b0;
        M_READY  = 1'b1;
        for (int k = 0; k < 10 && BUSY; k++) tick();
        check("t4_delivered", got_q.size(), 3);
        check("t4_busy_low", BUSY, 0);
        check("t4_rd_low", FIFO_RD_EN, 0);
        check("t4_valid_low", M_VALID, 0);
        if (got_q.size() == 3) check("t4_last_word", got_q[2], 8'hC2);

        // Reset while a word is buffered and another is in flight.
        DRAIN_EN = 1'b1;
        M_READY  = 1'b0;
        load(8'hD0, 3);
        for (int k = 0; k < 10 && !(exp_q.size() == 2 && pend_m); k++) tick();
        check("t5_valid_before_rst", M_VALID, 1);
        DRAIN_EN = 1'b0;
        do_reset();
        M_READY = 1'b1;
        clear_log();
        repeat (4) begin
            tick();
            check("t5_no_stale", M_VALID, 0);
        end
        DRAIN_EN = 1'b1;
        run_until(3, 20, "t5_count");
        if (got_q.size() == 3) check("t5_first_after_rst", got_q[0], 8'hD0);

        // Ten handshakes, then a stalled valid beat must not count.
        do_reset();
        clear_log();
        load(8'h50, 10);
        M_READY  = 1'b1;
        DRAIN_EN = 1'b1;
        run_until(10, 40, "t6_count");
        M_READY = 1'b0;
        load(8'h70, 3);
        for (int k = 0; k < 10 && !M_VALID; k++) tick();
        repeat (3) tick();
        check("t6_stall_valid", M_VALID, 1);
        check("t6_word_cnt", WORD_CNT, STATS ? 10 : 0);

        // Randomised traffic against the scoreboard.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            DRAIN_EN    = ($urandom_range(0, 9) != 0);
            M_READY     = ($urandom_range(0, 3) != 0);
            FIFO_WR_MON = ($urandom_range(0, 4) == 0) && (fifo_q.size() < 16);
            wr_data     = DW'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            tick();
        end
        FIFO_WR_MON = 1'b0;
        DRAIN_EN    = 1'b1;
        M_READY     = 1'b1;
        for (int k = 0; k < 200 && (exp_q.size() != 0 || fifo_q.size() != 0); k++) tick();
        check("final_drained", M_VALID, 0);
        check("final_fifo_empty", FIFO_EMPTY, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
